// File: rtl/fifo_read_ctrl.sv
// Read-side master for the synchronous FIFO.
// Drains words through a 2-entry skid buffer onto a valid/ready stream.
module fifo_read_ctrl #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  empty,
  input  logic                  underflow,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  underflow_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [FIFO_WIDTH-1:0] buf_q [2];
  logic [FIFO_WIDTH-1:0] buf_d [2];
  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic       pop;
  logic       push;
  logic [2:0] pend;

  // Output stage, taken straight from the skid registers.
  always_comb begin
    m_valid       = (occ_q != 2'd0);
    m_data        = m_valid ? buf_q[head_q] : '0;
    busy          = (state_q != IDLE);
    rd_count      = cnt_q;
    underflow_err = err_q;
  end

  // Read issue: never let buffered plus in-flight words exceed two.
  always_comb begin
    pop  = m_valid & m_ready;
    push = inflight_q & ~underflow;
    pend = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en = rst_n & (state_q == RUN) & enable & ~empty & (pend < 3'd2);
  end

  // Next-state logic for the run/stop sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN:  if (!enable) state_d = STOP;
      STOP: begin
        if (enable) state_d = RUN;
        else if (!inflight_q && occ_q == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Skid buffer, counters and sticky error update.
  always_comb begin
    buf_d[0]   = buf_q[0];
    buf_d[1]   = buf_q[1];
    head_d     = head_q ^ pop;
    tail_d     = tail_q ^ push;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    inflight_d = rd_en;
    cnt_d      = cnt_q;
    err_d      = err_q | (inflight_q & underflow);
    if (push) buf_d[tail_q] = data_out;
    if (pop && cnt_q != {CNT_WIDTH{1'b1}}) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      occ_q      <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && occ_q == 2'd2)
  );

endmodule
